// File: rtl/handshake_pkg.sv
// Shared defaults and derived widths for the handshake responder.
// Optional checker macro: HANDSHAKE_RESPONDER_PROTOCOL_CHECK_EN.
package handshake_pkg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
endpackage

// File: rtl/handshake_responder_mem.sv
// DEPTH x WIDTH register file for the responder FIFO.
// One synchronous write port, one asynchronous read port, no reset.
module handshake_responder_mem
  import handshake_pkg::*;
#(
  parameter int MW = handshake_pkg::WIDTH,
  parameter int MD = handshake_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [$clog2(MD)-1:0] waddr,
  input  logic [MW-1:0]         wdata,
  input  logic [$clog2(MD)-1:0] raddr,
  output logic [MW-1:0]         rdata
);

  logic [MW-1:0] mem [MD];

  // Capture the accepted word; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_responder.sv
// Consumer side of a valid/ready link, buffered by a small FIFO.
// Define HANDSHAKE_RESPONDER_PROTOCOL_CHECK_EN for the io_err checker.
module handshake_responder
  import handshake_pkg::*;
#(
  parameter int WIDTH = handshake_pkg::WIDTH,
  parameter int DEPTH = handshake_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_in_valid,
  input  logic [WIDTH-1:0]        io_in_bits,
  output logic                    io_in_ready,
  output logic                    io_out_valid,
  output logic [WIDTH-1:0]        io_out_bits,
  input  logic                    io_out_ready,
  output logic [$clog2(DEPTH):0]  io_count,
  output logic                    io_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign io_in_ready  = (count != CW'(DEPTH));
  assign io_out_valid = (count != '0);
  assign io_count     = count;
  assign push = io_in_valid && io_in_ready;
  assign pop  = io_out_valid && io_out_ready;

  handshake_responder_mem #(
    .MW (WIDTH),
    .MD (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (io_in_bits),
    .raddr (rd_ptr),
    .rdata (io_out_bits)
  );

  // Advance pointers and occupancy on each handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef HANDSHAKE_RESPONDER_PROTOCOL_CHECK_EN
  logic             stall_q;
  logic [WIDTH-1:0] bits_q;
  logic             err_q;
  logic             viol;

  assign viol = stall_q &&
                (!io_in_valid || (io_in_bits != bits_q));
  assign io_err = err_q;

  // Remember a stalled offer and flag it being withdrawn or altered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 1'b0;
      bits_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= io_in_valid && !io_in_ready;
      bits_q  <= io_in_bits;
      if (viol) err_q <= 1'b1;
    end
  end
`else
  assign io_err = 1'b0;
`endif

endmodule
